// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL wrapper / reset synchronisers.
// master = sequencer side, slave = PLL/top-level side.
interface pll_reset_sequencer_if #(
    parameter int NUM_CLOCKS = 4
);
    logic                  locked;
    logic                  retry_req;
    logic                  pll_rst;
    logic [NUM_CLOCKS-1:0] rst_out;
    logic                  lock_ok;
    logic                  fail;
    logic [7:0]            relock_cnt;

    modport master (
        input  locked,
        input  retry_req,
        output pll_rst,
        output rst_out,
        output lock_ok,
        output fail,
        output relock_cnt
    );

    modport slave (
        output locked,
        output retry_req,
        input  pll_rst,
        input  rst_out,
        input  lock_ok,
        input  fail,
        input  relock_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and lock supervisor: pulses the PLL reset, qualifies lock, releases
// per-domain resets in staggered order and re-arms the PLL on lock loss or timeout.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_RESET_PLL | pll_rst held high for RST_PULSE cycles
// S_WAIT_LOCK | PLL running, lock timer counting, waiting for locked_s
// S_STABLE    | locked_s seen, counting consecutive locked cycles
// S_RELEASE   | deasserting rst_out one domain every STAGGER cycles
// S_RUN       | all domains out of reset, lock supervised
// S_FAIL      | retry budget exhausted, waiting for retry_req
module pll_reset_sequencer #(
    parameter int NUM_CLOCKS  = 4,
    parameter int RST_PULSE   = 24,
    parameter int LOCK_WAIT   = 24000,
    parameter int LOCK_STABLE = 240,
    parameter int STAGGER     = 16,
    parameter int LOSS_FILT   = 4,
    parameter int MAX_RETRY   = 3
) (
    input logic                   refclk,
    input logic                   rst,
    pll_reset_sequencer_if.master bus
);

    localparam int PUL_W = $clog2(RST_PULSE + 1);
    localparam int TMR_W = $clog2(LOCK_WAIT + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam int STG_W = $clog2(STAGGER + 1);
    localparam int DIP_W = $clog2(LOSS_FILT + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam int IDX_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;

    localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(RST_PULSE - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_WAIT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER - 1);
    localparam logic [DIP_W-1:0] DIP_LAST = DIP_W'(LOSS_FILT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLOCKS - 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t                state_q,    state_d;
    logic [PUL_W-1:0]      pulse_q,    pulse_d;
    logic [TMR_W-1:0]      tmr_q,      tmr_d;
    logic [STB_W-1:0]      stab_q,     stab_d;
    logic [STG_W-1:0]      stag_q,     stag_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [DIP_W-1:0]      dip_q,      dip_d;
    logic [RTY_W-1:0]      retries_q,  retries_d;
    logic [7:0]            relock_q,   relock_d;
    logic                  pll_rst_q,  pll_rst_d;
    logic [NUM_CLOCKS-1:0] rst_out_q,  rst_out_d;
    logic                  lock_ok_q,  lock_ok_d;
    logic                  fail_q,     fail_d;
    logic                  sync1_q,    sync1_d;
    logic                  locked_s_q, locked_s_d;

    logic             timeout;
    logic [RTY_W-1:0] retries_inc;
    logic             tmr_hit;

    assign tmr_hit = (tmr_q == TMR_LAST);

    always_comb begin
        state_d     = state_q;
        pulse_d     = pulse_q;
        tmr_d       = tmr_q;
        stab_d      = stab_q;
        stag_d      = stag_q;
        idx_d       = idx_q;
        dip_d       = '0;
        retries_d   = retries_q;
        relock_d    = relock_q;
        pll_rst_d   = pll_rst_q;
        rst_out_d   = rst_out_q;
        lock_ok_d   = lock_ok_q;
        fail_d      = fail_q;
        sync1_d     = bus.locked;
        locked_s_d  = sync1_q;
        timeout     = 1'b0;
        retries_inc = retries_q + RTY_W'(1);

        case (state_q)
            S_RESET_PLL: begin
                pll_rst_d = 1'b1;
                rst_out_d = '1;
                lock_ok_d = 1'b0;
                fail_d    = 1'b0;
                if (pulse_q == PUL_LAST) begin
                    state_d   = S_WAIT_LOCK;
                    pulse_d   = '0;
                    tmr_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    pulse_d = pulse_q + PUL_W'(1);
                end
            end

            S_WAIT_LOCK: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_hit) begin
                    timeout = 1'b1;
                end else if (locked_s_q) begin
                    state_d = S_STABLE;
                    stab_d  = '0;
                end
            end

            // Stable completion outranks a timeout landing on the same edge.
            S_STABLE: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (locked_s_q && (stab_q == STB_LAST)) begin
                    state_d = S_RELEASE;
                    stag_d  = '0;
                    idx_d   = '0;
                end else if (tmr_hit) begin
                    timeout = 1'b1;
                end else if (!locked_s_q) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    stab_d = stab_q + STB_W'(1);
                end
            end

            S_RELEASE, S_RUN: begin
                if (!locked_s_q && (dip_q == DIP_LAST)) begin
                    state_d   = S_RESET_PLL;
                    pulse_d   = '0;
                    pll_rst_d = 1'b1;
                    rst_out_d = '1;
                    lock_ok_d = 1'b0;
                    retries_d = '0;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end else begin
                    if (!locked_s_q) begin
                        dip_d = dip_q + DIP_W'(1);
                    end
                    if (state_q == S_RELEASE) begin
                        if (stag_q == STG_LAST) begin
                            stag_d           = '0;
                            rst_out_d[idx_q] = 1'b0;
                            idx_d            = idx_q + IDX_W'(1);
                            if (idx_q == IDX_LAST) begin
                                state_d   = S_RUN;
                                lock_ok_d = 1'b1;
                            end
                        end else begin
                            stag_d = stag_q + STG_W'(1);
                        end
                    end
                end
            end

            S_FAIL: begin
                pll_rst_d = 1'b1;
                rst_out_d = '1;
                lock_ok_d = 1'b0;
                fail_d    = 1'b1;
                if (bus.retry_req) begin
                    state_d   = S_RESET_PLL;
                    pulse_d   = '0;
                    fail_d    = 1'b0;
                    retries_d = '0;
                end
            end

            default: begin
                state_d   = S_RESET_PLL;
                pulse_d   = '0;
                pll_rst_d = 1'b1;
                rst_out_d = '1;
                lock_ok_d = 1'b0;
            end
        endcase

        if (timeout) begin
            retries_d = retries_inc;
            pll_rst_d = 1'b1;
            pulse_d   = '0;
            if (retries_inc == RTY_MAX) begin
                state_d = S_FAIL;
                fail_d  = 1'b1;
            end else begin
                state_d = S_RESET_PLL;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= S_RESET_PLL;
            pulse_q    <= '0;
            tmr_q      <= '0;
            stab_q     <= '0;
            stag_q     <= '0;
            idx_q      <= '0;
            dip_q      <= '0;
            retries_q  <= '0;
            relock_q   <= '0;
            pll_rst_q  <= 1'b1;
            rst_out_q  <= '1;
            lock_ok_q  <= 1'b0;
            fail_q     <= 1'b0;
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pulse_q    <= pulse_d;
            tmr_q      <= tmr_d;
            stab_q     <= stab_d;
            stag_q     <= stag_d;
            idx_q      <= idx_d;
            dip_q      <= dip_d;
            retries_q  <= retries_d;
            relock_q   <= relock_d;
            pll_rst_q  <= pll_rst_d;
            rst_out_q  <= rst_out_d;
            lock_ok_q  <= lock_ok_d;
            fail_q     <= fail_d;
            sync1_q    <= sync1_d;
            locked_s_q <= locked_s_d;
        end
    end

    assign bus.pll_rst    = pll_rst_q;
    assign bus.rst_out    = rst_out_q;
    assign bus.lock_ok    = lock_ok_q;
    assign bus.fail       = fail_q;
    assign bus.relock_cnt = relock_q;

endmodule
